// File: rtl/axi_buffer_rr_arb.sv
// axi_buffer_rr_arb: packet-aware round-robin arbiter feeding one buffer write port.
// A grant is held from a packet's first beat until its last beat is accepted.
module axi_buffer_rr_arb #(
    parameter int NUM_REQ     = 4,
    parameter int LOG_NUM_REQ = 2,
    parameter int DATA_WIDTH  = 32,
    parameter int CNT_WIDTH   = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            valid_in,
    input  logic [NUM_REQ-1:0]            last_in,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] data_in,
    output logic [NUM_REQ-1:0]            ready_out,
    output logic [DATA_WIDTH-1:0]         data_out,
    output logic                          valid_out,
    output logic                          last_out,
    output logic [LOG_NUM_REQ-1:0]        id_out,
    input  logic                          ready_in,
    output logic [CNT_WIDTH-1:0]          beat_cnt
);
    typedef enum logic {IDLE, LOCKED} state_t;

    state_t                 state, state_nxt;
    logic [LOG_NUM_REQ-1:0] grant, grant_nxt, rr_ptr, rr_ptr_nxt, winner, sel;
    logic [CNT_WIDTH-1:0]   cnt, cnt_nxt;
    logic                   any, acc, locked;
    logic [DATA_WIDTH-1:0]  data_arr [NUM_REQ];

    function automatic logic [LOG_NUM_REQ-1:0] wrap_inc(input logic [LOG_NUM_REQ-1:0] x);
        return (int'(x) == NUM_REQ - 1) ? '0 : x + 1'b1;
    endfunction

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign data_arr[g] = data_in[g*DATA_WIDTH +: DATA_WIDTH];
    end

    // Scan from the farthest candidate back to rr_ptr so the nearest valid one wins.
    always_comb begin : p_winner
        int s;
        any    = 1'b0;
        winner = rr_ptr;
        s      = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            s = int'(rr_ptr) + k;
            if (s >= NUM_REQ) s = s - NUM_REQ;
            if (valid_in[LOG_NUM_REQ'(s)]) begin
                any    = 1'b1;
                winner = LOG_NUM_REQ'(s);
            end
        end
    end

    assign locked   = (state == LOCKED);
    assign sel      = locked ? grant : winner;
    assign acc      = valid_out & ready_in;
    assign beat_cnt = cnt;

    always_comb begin
        valid_out = ~rst & (locked ? valid_in[grant] : any);
        last_out  = last_in[sel];
        data_out  = data_arr[sel];
        id_out    = (locked || any) ? sel : grant;
        ready_out = '0;
        if (!rst && (locked || any)) ready_out[sel] = ready_in;
    end

    always_comb begin
        state_nxt  = state;
        grant_nxt  = grant;
        rr_ptr_nxt = rr_ptr;
        cnt_nxt    = cnt;
        if (!locked) begin
            if (any && ready_in && last_in[winner]) begin
                rr_ptr_nxt = wrap_inc(winner);
            end else if (any) begin
                state_nxt = LOCKED;
                grant_nxt = winner;
                cnt_nxt   = ready_in ? CNT_WIDTH'(1) : '0;
            end
        end else if (acc && last_out) begin
            state_nxt  = IDLE;
            rr_ptr_nxt = wrap_inc(grant);
            cnt_nxt    = '0;
        end else if (acc && !(&cnt)) begin
            cnt_nxt = cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            grant  <= '0;
            rr_ptr <= '0;
            cnt    <= '0;
        end else begin
            state  <= state_nxt;
            grant  <= grant_nxt;
            rr_ptr <= rr_ptr_nxt;
            cnt    <= cnt_nxt;
        end
    end
endmodule

// File: tb/tb_axi_buffer_rr_arb.sv
// tb_axi_buffer_rr_arb: directed scenario checks for the packet-aware round-robin arbiter.
module tb_axi_buffer_rr_arb;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   valid_in = '0, last_in = '0, ready_out;
    logic [127:0] data_in = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    logic [31:0]  data_out;
    logic         valid_out, last_out, ready_in = 1'b0;
    logic [1:0]   id_out;
    logic [7:0]   beat_cnt;
    logic [15:0]  obs;
    int           n_cmp = 0, n_fail = 0;

    axi_buffer_rr_arb dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .last_in(last_in), .data_in(data_in),
        .ready_out(ready_out), .data_out(data_out), .valid_out(valid_out), .last_out(last_out),
        .id_out(id_out), .ready_in(ready_in), .beat_cnt(beat_cnt)
    );

    always #5 clk = ~clk;

    assign obs = {valid_out, last_out, ready_out, id_out, beat_cnt};

    function automatic logic [15:0] pk(input logic v, input logic l, input logic [3:0] ro,
                                       input logic [1:0] id, input logic [7:0] c);
        return {v, l, ro, id, c};
    endfunction

    task automatic drive(input logic [3:0] v, input logic [3:0] l, input logic r);
        valid_in = v;
        last_in  = l;
        ready_in = r;
        #1;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        drive(4'h0, 4'h0, 1'b0);
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(4'hF, 4'hF, 1'b1);
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if ({valid_out, ready_out} !== 5'b0) begin
                n_fail++;
                $display("FAIL reset_hold[%0d]: got v=%b r=%b want v=0 r=0000", k, valid_out, ready_out);
            end
            step();
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (obs !== pk(1, 1, 4'b0001, 0, 0) || data_out !== 32'h1111_1111) begin
            n_fail++;
            $display("FAIL reset_release: got %h data %h want %h data 11111111", obs, data_out, pk(1, 1, 4'b0001, 0, 0));
        end
        step();
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_id [6] = '{0, 1, 2, 3, 0, 1};
        reset_dut();
        for (int k = 0; k < 6; k++) begin
            drive(4'hF, 4'hF, 1'b1);
            n_cmp++;
            if (obs !== pk(1, 1, 4'b0001 << exp_id[k], exp_id[k], 0)) begin
                n_fail++;
                $display("FAIL rr_seq[%0d]: got %h want %h", k, obs, pk(1, 1, 4'b0001 << exp_id[k], exp_id[k], 0));
            end
            step();
        end
    endtask

    task automatic test_packet_lock();
        logic [3:0] lst  [4] = '{4'b0100, 4'b0100, 4'b0110, 4'b0100};
        logic [15:0] exp [4];
        exp = '{pk(1, 0, 4'b0010, 1, 0), pk(1, 0, 4'b0010, 1, 1),
                pk(1, 1, 4'b0010, 1, 2), pk(1, 1, 4'b0100, 2, 0)};
        reset_dut();
        for (int k = 0; k < 4; k++) begin
            drive(4'b0110, lst[k], 1'b1);
            n_cmp++;
            if (obs !== exp[k]) begin
                n_fail++;
                $display("FAIL lock[%0d]: got %h want %h", k, obs, exp[k]);
            end
            step();
        end
    endtask

    task automatic test_back_pressure();
        reset_dut();
        drive(4'b0100, 4'b0100, 1'b1);
        step();
        for (int k = 0; k < 5; k++) begin
            drive(4'b1001, 4'b1001, 1'b0);
            n_cmp++;
            if (obs !== pk(1, 1, 4'b0000, 3, 0) || data_out !== 32'h4444_4444) begin
                n_fail++;
                $display("FAIL bp_stall[%0d]: got %h data %h want %h data 44444444", k, obs, data_out, pk(1, 1, 4'b0000, 3, 0));
            end
            step();
        end
        drive(4'b1001, 4'b1001, 1'b1);
        n_cmp++;
        if (obs !== pk(1, 1, 4'b1000, 3, 0) || data_out !== 32'h4444_4444) begin
            n_fail++;
            $display("FAIL bp_release: got %h data %h want %h", obs, data_out, pk(1, 1, 4'b1000, 3, 0));
        end
        step();
        drive(4'b0001, 4'b0001, 1'b1);
        n_cmp++;
        if (obs !== pk(1, 1, 4'b0001, 0, 0)) begin
            n_fail++;
            $display("FAIL bp_next: got %h want %h", obs, pk(1, 1, 4'b0001, 0, 0));
        end
        step();
    endtask

    task automatic test_bubble_wrap();
        logic [3:0] vld [5] = '{4'b1000, 4'b0010, 4'b0010, 4'b1010, 4'b1011};
        logic [3:0] lst [5] = '{4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b0000};
        logic [15:0] exp [5];
        exp = '{pk(1, 0, 4'b1000, 3, 0), pk(0, 0, 4'b1000, 3, 1), pk(0, 0, 4'b1000, 3, 1),
                pk(1, 1, 4'b1000, 3, 1), pk(1, 0, 4'b0001, 0, 0)};
        reset_dut();
        drive(4'b0100, 4'b0100, 1'b1);
        step();
        for (int k = 0; k < 5; k++) begin
            drive(vld[k], lst[k], 1'b1);
            n_cmp++;
            if (obs !== exp[k]) begin
                n_fail++;
                $display("FAIL bubble[%0d]: got %h want %h", k, obs, exp[k]);
            end
            step();
        end
    endtask

    task automatic test_reset_mid_packet();
        reset_dut();
        drive(4'b0010, 4'b0010, 1'b1);
        step();
        drive(4'b0100, 4'b0000, 1'b1);
        step();
        step();
        n_cmp++;
        if (obs !== pk(1, 0, 4'b0100, 2, 2)) begin
            n_fail++;
            $display("FAIL mid_cnt: got %h want %h", obs, pk(1, 0, 4'b0100, 2, 2));
        end
        rst = 1'b1;
        drive(4'b0101, 4'b0000, 1'b1);
        n_cmp++;
        if ({valid_out, ready_out} !== 5'b0) begin
            n_fail++;
            $display("FAIL mid_rst: got v=%b r=%b want v=0 r=0000", valid_out, ready_out);
        end
        step();
        rst = 1'b0;
        #1;
        n_cmp++;
        if (obs !== pk(1, 0, 4'b0001, 0, 0)) begin
            n_fail++;
            $display("FAIL mid_after: got %h want %h", obs, pk(1, 0, 4'b0001, 0, 0));
        end
        step();
    endtask

    task automatic test_saturation();
        reset_dut();
        for (int k = 0; k < 258; k++) begin
            drive(4'b0001, 4'b0000, 1'b1);
            step();
        end
        drive(4'b0001, 4'b0001, 1'b1);
        n_cmp++;
        if (obs !== pk(1, 1, 4'b0001, 0, 8'hFF)) begin
            n_fail++;
            $display("FAIL sat: got %h want %h", obs, pk(1, 1, 4'b0001, 0, 8'hFF));
        end
        step();
        drive(4'b0000, 4'b0000, 1'b1);
        n_cmp++;
        if ({valid_out, ready_out, beat_cnt} !== 13'b0) begin
            n_fail++;
            $display("FAIL sat_clear: got v=%b r=%b cnt=%0d want 0", valid_out, ready_out, beat_cnt);
        end
        step();
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_round_robin();
        test_packet_lock();
        test_back_pressure();
        test_bubble_wrap();
        test_reset_mid_packet();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/axi_buffer_rr_arb.md
Name: axi_buffer_rr_arb

Overview:
- Round-robin, packet-aware arbiter that shares one buffer write port among NUM_REQ upstream valid/ready streams.
- Sits directly in front of the buffer's upstream port: data_out/valid_out/last_out drive the buffer input, and ready_in is the buffer's ready_out.
- Once a requester is granted, the grant is held until that requester's last beat has been accepted, so packets are never interleaved.
- Also exports the granted index and a per-packet beat count for ID tagging and debug.

Parameters:
- NUM_REQ, 4, number of requesters (2..16, need not be a power of 2).
- LOG_NUM_REQ, 2, width of requester index, ceil(log2(NUM_REQ)).
- DATA_WIDTH, 32, payload width per beat.
- CNT_WIDTH, 8, width of beat counter.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous reset, active-high.
- valid_in  in  NUM_REQ  per-requester valid.
- last_in  in  NUM_REQ  per-requester last-beat flag, qualified by valid_in.
- data_in  in  NUM_REQ*DATA_WIDTH  payloads; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- ready_out  out  NUM_REQ  per-requester ready.
- data_out  out  DATA_WIDTH  muxed payload to buffer.
- valid_out  out  1  beat valid to buffer.
- last_out  out  1  last flag of muxed beat.
- id_out  out  LOG_NUM_REQ  index of requester currently driving data_out.
- ready_in  in  1  buffer ready (buffer not full).
- beat_cnt  out  CNT_WIDTH  beats accepted so far in current packet.

Behaviour:
- State machine: IDLE, LOCKED; a grant register; a priority pointer rr_ptr (0..NUM_REQ-1).
- Reset (rst high at clk edge): state=IDLE, grant=0, rr_ptr=0, beat_cnt=0. While rst is high, valid_out=0 and ready_out=0 combinationally, regardless of inputs.
- IDLE, winner selection (combinational): winner = first i with valid_in[i], searching rr_ptr, rr_ptr+1, ... with explicit wrap at NUM_REQ-1 → 0.
- IDLE, no valid_in: valid_out=0, ready_out=0, id_out=grant (don't-care to the buffer).
- IDLE, winner exists:
  - Zero-latency pass-through: valid_out=1, data_out/last_out/id_out from the winner, ready_out[winner]=ready_in, all others 0.
  - Winner's last beat accepted (ready_in=1 and last_in=1): stay IDLE, rr_ptr=winner+1 (wrapped), beat_cnt=0.
  - Any other case, including non-last beat accepted or ready_in=0 stall: go to LOCKED, grant=winner.
  - On entering LOCKED, beat_cnt=1 if the beat was accepted, else 0.
- LOCKED:
  - Only the grant requester is multiplexed: valid_out=valid_in[grant], ready_out[grant]=ready_in, all others 0; other requesters' valid_in is ignored.
  - Each accepted beat (valid_out & ready_in) increments beat_cnt.
  - beat_cnt saturates at all-ones; it never wraps.
  - Accepted beat with last_out=1: go to IDLE, rr_ptr=grant+1 (wrapped), beat_cnt=0.
  - Granted requester drops valid mid-packet: stay LOCKED; valid_out=0 (bubble); nothing transfers.
- Fairness: a requester with a pending valid is granted within NUM_REQ-1 completed packets.
- Single-beat packets (last_in=1 on first beat) never enter LOCKED when ready_in=1.
- Reset mid-packet: abandons the packet. Next cycle after rst deasserts the block is in IDLE, rr_ptr=0, and nothing is transferred during the reset cycle.
- No combinational path from ready_in to valid_out. ready_in→ready_out and valid_in→valid_out are combinational by design; the downstream buffer registers.

Test Plan:
- Reset: hold rst 3 cycles with all valid_in=1 → valid_out=0, ready_out=0; on release, requester 0 granted first (id_out=0).
- Round robin, NUM_REQ=4: all valid, 1-beat packets, ready_in=1 → id_out sequence 0,1,2,3,0,1 on consecutive cycles, one beat per cycle.
- Packet lock: req1 sends 3 beats (last on 3rd) while req2 is valid throughout → id_out=1 for 3 accepted beats, beat_cnt 0,1,2 then reset to 0; req2 granted on the next cycle.
- Back-pressure: winner req3, ready_in=0 for 5 cycles while req0 also asserts valid → grant stays 3, ready_out=0000, data_out stable; ready_in=1 transfers req3's beat first.
- Bubble and wrap: req3 granted, drops valid for 2 cycles mid-packet → valid_out=0 for those cycles, no switch; after last beat, rr_ptr wraps to 0.
- Reset mid-packet: assert rst after 2 of 4 beats of req2 → next cycle IDLE, beat_cnt=0, rr_ptr=0; a pending req0 is granted before req2.
